// File: rtl/ops_arbiter.sv
// ============================================================================
// Module      : ops_arbiter
// Description : Two-requester round-robin controller for a shared
//               combinational operations unit. It grants one operand pair at
//               a time, drives the unit's A/B inputs, waits SETTLE cycles,
//               captures C and returns it with the requester ID over a
//               valid/ready response channel.
//               Optional macro OPS_ARB_STATS_EN adds a saturating 16-bit
//               completed-transaction counter on port ops_count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ops_arbiter #(
    parameter int WIDTH  = 12,
    parameter int SETTLE = 2     // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r0_valid,
    input  logic [WIDTH-1:0] r0_a,
    input  logic [WIDTH-1:0] r0_b,
    output logic             r0_ready,
    input  logic             r1_valid,
    input  logic [WIDTH-1:0] r1_a,
    input  logic [WIDTH-1:0] r1_b,
    output logic             r1_ready,
    output logic [WIDTH-1:0] op_a,
    output logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] op_c,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id
`ifdef OPS_ARB_STATS_EN
    ,
    output logic [15:0]      ops_count
`endif
);

    // The settle counter is loaded with SETTLE-1 so capture lands SETTLE
    // edges after the accept edge.
    localparam logic [3:0] c_settle_init = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_rr;       // round-robin pointer: requester favoured on a tie
    logic [3:0] r_cnt;

    logic       w_any;
    logic       w_grant;    // index of the requester that would be granted
    logic       w_accept;

    // Grant selection: a lone valid wins, a tie goes to the rr pointer.
    // rst_n gates acceptance so both readys read low while reset is asserted.
    always_comb begin
        w_any    = r0_valid | r1_valid;
        w_grant  = (r0_valid & r1_valid) ? r_rr : r1_valid;
        w_accept = (r_state == S_IDLE) & w_any & rst_n;
    end

    assign r0_ready = w_accept & ~w_grant;
    assign r1_ready = w_accept &  w_grant;

    // Transaction FSM: accept -> settle -> hold response until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rr       <= 1'b0;
            r_cnt      <= 4'd0;
            op_a       <= '0;
            op_b       <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_id    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        op_a    <= w_grant ? r1_a : r0_a;
                        op_b    <= w_grant ? r1_b : r0_b;
                        resp_id <= w_grant;
                        r_rr    <= ~w_grant;
                        r_cnt   <= c_settle_init;
                        r_state <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        resp_data  <= op_c;
                        resp_valid <= 1'b1;
                        r_state    <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef OPS_ARB_STATS_EN
    // Completed-transaction counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ops_count <= 16'd0;
        end else if ((r_state == S_RESP) && resp_ready && (ops_count != 16'hFFFF)) begin
            ops_count <= ops_count + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ops_arbiter.sv
// ============================================================================
// Module      : tb_ops_arbiter
// Description : Self-checking bench for ops_arbiter with an A+B stub unit and
//               a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ops_arbiter;

    localparam int WIDTH  = 12;
    localparam int SETTLE = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             r0_valid, r1_valid;
    logic [WIDTH-1:0] r0_a, r0_b, r1_a, r1_b;
    logic             r0_ready, r1_ready;
    logic [WIDTH-1:0] op_a, op_b, op_c;
    logic             resp_valid, resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic             resp_id;
`ifdef OPS_ARB_STATS_EN
    logic [15:0]      ops_count;
`endif

    always #5 clk = ~clk;

    // Stub operations unit: C = A + B mod 4096
    assign op_c = op_a + op_b;

    ops_arbiter #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .r0_valid   (r0_valid),
        .r0_a       (r0_a),
        .r0_b       (r0_b),
        .r0_ready   (r0_ready),
        .r1_valid   (r1_valid),
        .r1_a       (r1_a),
        .r1_b       (r1_b),
        .r1_ready   (r1_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_c       (op_c),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
`ifdef OPS_ARB_STATS_EN
        ,
        .ops_count  (ops_count)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: transaction phase plus last accepted/captured values
    bit               m_busy, m_resp, m_rr, m_id;
    int               m_k;
    logic [WIDTH-1:0] m_a, m_b, m_data;
    int               m_count;

    // Observation bookkeeping for directed checks
    int               cyc, acc_cyc, seen_cyc, r0_rdy_cnt, r1_rdy_cnt;
    bit               prev_rv, hs_done;
    logic [WIDTH-1:0] obs_data;
    logic             obs_id;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_resp = 0; m_rr = 0; m_id = 0; m_k = 0;
        m_a = '0; m_b = '0; m_data = '0; m_count = 0;
        prev_rv = 0;
    endtask

    // One clock: entered just after a falling edge with inputs already set.
    task automatic cycle();
        int  g;
        bit  idle;
        int  clr;
        #1;
        idle = !m_busy && !m_resp;
        g = -1;
        if (idle && r0_valid && r1_valid) g = m_rr ? 1 : 0;
        else if (idle && r0_valid)        g = 0;
        else if (idle && r1_valid)        g = 1;
        check("r0_ready",   32'(r0_ready),   32'(g == 0));
        check("r1_ready",   32'(r1_ready),   32'(g == 1));
        check("resp_valid", 32'(resp_valid), 32'(m_resp));
        check("resp_data",  32'(resp_data),  32'(m_data));
        check("resp_id",    32'(resp_id),    32'(m_id));
        check("op_a",       32'(op_a),       32'(m_a));
        check("op_b",       32'(op_b),       32'(m_b));
`ifdef OPS_ARB_STATS_EN
        check("ops_count",  32'(ops_count),  32'(m_count));
`endif
        if (r0_ready) r0_rdy_cnt++;
        if (r1_ready) r1_rdy_cnt++;
        if (resp_valid && !prev_rv) seen_cyc = cyc;
        if (resp_valid) begin
            obs_data = resp_data;
            obs_id   = resp_id;
        end
        prev_rv = resp_valid;
        clr = -1;
        @(posedge clk);
        if (m_resp) begin
            if (resp_ready) begin
                m_resp  = 0;
                hs_done = 1;
                if (m_count < 65535) m_count++;
            end
        end else if (m_busy) begin
            m_k++;
            if (m_k == SETTLE) begin
                m_busy = 0;
                m_resp = 1;
                m_data = m_a + m_b;
            end
        end else if (g >= 0) begin
            m_a     = (g == 1) ? r1_a : r0_a;
            m_b     = (g == 1) ? r1_b : r0_b;
            m_id    = (g == 1);
            m_rr    = (g == 0);
            m_busy  = 1;
            m_k     = 0;
            acc_cyc = cyc;
            clr     = g;
        end
        cyc++;
        @(negedge clk);
        // Accepted requester withdraws its valid, as a client would
        if (clr == 0) r0_valid = 1'b0;
        if (clr == 1) r1_valid = 1'b0;
    endtask

    // Run until one response handshake completes, bounded.
    task automatic serve(input int budget);
        hs_done = 0;
        for (int i = 0; i < budget && !hs_done; i++) cycle();
        if (!hs_done) check("serve_timeout", 32'd0, 32'd1);
    endtask

    // Asynchronous reset pulse issued mid-cycle.
    task automatic reset_pulse();
        #2;
        rst_n    = 1'b0;
        r0_valid = 1'b1;
        #1;
        model_reset();
        check("rst_r0_ready",   32'(r0_ready),   32'd0);
        check("rst_r1_ready",   32'(r1_ready),   32'd0);
        check("rst_op_a",       32'(op_a),       32'd0);
        check("rst_op_b",       32'(op_b),       32'd0);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_data",  32'(resp_data),  32'd0);
        check("rst_resp_id",    32'(resp_id),    32'd0);
        @(posedge clk);
        @(negedge clk);
        r0_valid = 1'b0;
        r1_valid = 1'b0;
        rst_n    = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; r0_valid = 0; r1_valid = 0; resp_ready = 0;
        r0_a = '0; r0_b = '0; r1_a = '0; r1_b = '0;
        cyc = 0; acc_cyc = 0; seen_cyc = 0; r0_rdy_cnt = 0; r1_rdy_cnt = 0;
        obs_data = '0; obs_id = 0; hs_done = 0;
        model_reset();
        @(negedge clk);
        reset_pulse();

        // Single request, a=0x0FF b=0x001
        r0_rdy_cnt = 0; r1_rdy_cnt = 0;
        r0_a = 12'h0FF; r0_b = 12'h001; r0_valid = 1; resp_ready = 1;
        serve(20);
        check("t1_data",    32'(obs_data), 32'h100);
        check("t1_id",      32'(obs_id),   32'd0);
        check("t1_latency", 32'(seen_cyc - acc_cyc - 1), 32'(SETTLE));
        check("t1_r0_rdy",  32'(r0_rdy_cnt), 32'd1);
        check("t1_r1_rdy",  32'(r1_rdy_cnt), 32'd0);

        // Simultaneous requests from reset, twice, alternating pointer
        reset_pulse();
        for (int p = 0; p < 2; p++) begin
            r0_a = 12'h001; r0_b = 12'h002; r1_a = 12'h010; r1_b = 12'h020;
            r0_valid = 1; r1_valid = 1;
            serve(20);
            check("t2_first_id",    32'(obs_id),   32'd0);
            check("t2_first_data",  32'(obs_data), 32'h003);
            serve(20);
            check("t2_second_id",   32'(obs_id),   32'd1);
            check("t2_second_data", 32'(obs_data), 32'h030);
        end

        // Back-pressure: resp_ready low for 5 cycles with resp_valid high
        resp_ready = 0;
        r0_a = 12'h123; r0_b = 12'h456; r0_valid = 1;
        for (int i = 0; i < 20 && !resp_valid; i++) cycle();
        r1_a = 12'h00A; r1_b = 12'h00B; r1_valid = 1;
        r0_rdy_cnt = 0; r1_rdy_cnt = 0;
        repeat (5) cycle();
        check("t3_held_valid", 32'(resp_valid), 32'd1);
        check("t3_held_data",  32'(resp_data),  32'h579);
        check("t3_r1_rdy",     32'(r1_rdy_cnt), 32'd0);
        resp_ready = 1;
        hs_done = 0;
        cycle();
        check("t3_handshake", 32'(hs_done), 32'd1);
        serve(20);
        check("t3_next_id",   32'(obs_id),   32'd1);
        check("t3_next_data", 32'(obs_data), 32'h015);

        // Wrap-around on requester 1
        r1_a = 12'hFFF; r1_b = 12'h002; r1_valid = 1;
        serve(20);
        check("t4_data", 32'(obs_data), 32'h001);
        check("t4_id",   32'(obs_id),   32'd1);

        // Reset during SETTLE drops the transaction
        r0_a = 12'h111; r0_b = 12'h222; r0_valid = 1;
        cycle();
        cycle();
        reset_pulse();
        seen_cyc = -1;
        repeat (6) cycle();
        check("t5_no_resp", 32'(seen_cyc), 32'hFFFF_FFFF);
        r0_a = 12'h005; r0_b = 12'h006; r1_a = 12'h007; r1_b = 12'h008;
        r0_valid = 1; r1_valid = 1;
        serve(20);
        check("t5_after_id",   32'(obs_id),   32'd0);
        check("t5_after_data", 32'(obs_data), 32'h00B);
        serve(20);

`ifdef OPS_ARB_STATS_EN
        reset_pulse();
        for (int t = 0; t < 3; t++) begin
            r0_a = 12'(t); r0_b = 12'h010; r0_valid = 1;
            serve(20);
        end
        check("t6_count3", 32'(ops_count), 32'd3);
        force dut.ops_count = 16'hFFFF;
        #1;
        release dut.ops_count;
        m_count = 65535;
        r1_a = 12'h001; r1_b = 12'h001; r1_valid = 1;
        serve(20);
        check("t6_saturate", 32'(ops_count), 32'hFFFF);
`endif

        // Randomized traffic with random back-pressure and withdrawals
        for (int i = 0; i < 400; i++) begin
            if (!r0_valid && ($urandom % 3 == 0)) begin
                r0_a = 12'($urandom); r0_b = 12'($urandom); r0_valid = 1;
            end else if (r0_valid && ($urandom % 16 == 0)) begin
                r0_valid = 0;
            end
            if (!r1_valid && ($urandom % 3 == 0)) begin
                r1_a = 12'($urandom); r1_b = 12'($urandom); r1_valid = 1;
            end else if (r1_valid && ($urandom % 16 == 0)) begin
                r1_valid = 0;
            end
            resp_ready = 1'($urandom % 2);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ops_arbiter.md
# ops_arbiter

Two-requester round-robin controller for the shared 12-bit combinational operations unit (inputs A, B; output C). It accepts operand pairs from two clients over valid/ready handshakes and drives the unit's A/B inputs for one transaction at a time. It samples C after a programmable settle time and returns the result, tagged with the requester ID, over a valid/ready response channel. It sits between the register-level clients and the operations datapath, which has no clock of its own.

## Interface
- WIDTH, 12, operand/result width; matches the operations unit.
- SETTLE, 2, cycles C is allowed to settle after A/B change before capture; legal range 1..15.

- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- r0_valid / r1_valid  in  1  requester has an operand pair.
- r0_a, r0_b / r1_a, r1_b  in  WIDTH  operands.
- r0_ready / r1_ready  out  1  transaction accepted on this edge when high with valid.
- op_a, op_b  out  WIDTH  drive operations unit A, B.
- op_c  in  WIDTH  operations unit C.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes result.
- resp_data  out  WIDTH  captured C.
- resp_id  out  1  requester index (0/1).
- ops_count  out  16  completed transactions; present only with OPS_ARB_STATS_EN.

## Operation
- FSM states: IDLE, SETTLE, RESP.
- IDLE: grant is combinational. If exactly one valid is high, that requester is granted. If both are high, the requester named by round-robin pointer `rr` is granted. The granted rX_ready is high only in IDLE; the other requester's ready is low. On the accept edge: op_a/op_b <= granted operands, resp_id <= grant, `rr` <= ~grant, settle counter <= SETTLE-1, state -> SETTLE.
- SETTLE: counter decrements each cycle. On the edge where the counter is 0: resp_data <= op_c, resp_valid <= 1, state -> RESP.
- RESP: resp_valid is held high and resp_data/resp_id stay stable until resp_valid & resp_ready is sampled. On that edge resp_valid <= 0 and state -> IDLE. Both readys stay low throughout.
- op_a/op_b hold their last values outside IDLE and after completion. They change only on an accept edge.
- Requesters with valid low are never granted. `rr` changes only on accept.
- Arithmetic is done entirely in the operations unit. resp_data is C truncated/extended to WIDTH with no modification.

## Timing
- Reset values: r0_ready=r1_ready=0 while in reset, op_a=op_b=0, resp_valid=0, resp_data=0, resp_id=0, ops_count=0, rr=0 (r0 favoured), state IDLE.
- Accept edge E0: op_a/op_b are valid after E0.
- Capture edge is E0+SETTLE. resp_valid is high from that edge, so latency from accept to resp_valid is SETTLE cycles.
- The earliest next accept is the edge after the resp handshake edge. Throughput is at most one transaction per SETTLE+2 cycles.
- resp_ready held high in RESP means resp_valid is high for exactly one cycle.
- Reset asserted mid-SETTLE or mid-RESP: the transaction is dropped and no response is produced. All outputs go to reset values immediately, because reset is asynchronous.
- A requester dropping valid after acceptance has no effect. Valid dropped before acceptance means no grant.

## Configuration
- OPS_ARB_STATS_EN defined: the ops_count port and a 16-bit counter exist. The counter increments on each response handshake, saturates at 0xFFFF, and is cleared by rst_n.
- Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
All scenarios use a stub unit computing C = A + B mod 4096, with SETTLE=2.
- Single request, r0_a=0x0FF, r0_b=0x001, resp_ready=1 -> r0_ready high one cycle; resp_valid 2 cycles after accept with resp_data=0x100, resp_id=0; r1_ready stays 0.
- r0 and r1 valid simultaneously from reset, r0 (0x001, 0x002), r1 (0x010, 0x020) -> r0 served first (0x003, id 0), then r1 (0x030, id 1). A second simultaneous pair is served r0 then r1 again, confirming pointer alternation.
- resp_ready low for 5 cycles after resp_valid -> resp_valid, resp_data and resp_id are stable for all 5 cycles; r0_ready and r1_ready stay 0; handshake on the 6th cycle returns to IDLE.
- Wrap-around, r1_a=0xFFF, r1_b=0x002 -> resp_data=0x001, resp_id=1.
- rst_n pulsed low during SETTLE -> no resp_valid is ever produced; op_a=op_b=0; the next request is served normally with rr=0.
- With OPS_ARB_STATS_EN, 3 completed transactions -> ops_count=3. A counter forced to 0xFFFF stays 0xFFFF after a further transaction.
